// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-lite types: response codes, channel FSM states and default widths.
package axi4_lite_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Word-wide register array with one synchronous write port, one combinational
// read port and a flattened view of every register for local hardware.
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           wr_en_i,
  input  logic [IDX_W-1:0]               wr_idx_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic [IDX_W-1:0]               rd_idx_i,
  output logic [DATA_WIDTH-1:0]          rd_data_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Read sees the pre-write value, so a same-edge read/write returns old data.
  assign rd_data_o = regs_q[rd_idx_i];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-lite responder backing NUM_REGS full-word CSRs; independent write and
// read channel FSMs with address decode, register storage in the reg bank.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

  wr_state_e             wrState_q, wrState_d;
  logic                  awHeld_q, awHeld_d;
  logic                  wHeld_q, wHeld_d;
  logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
  logic [DATA_WIDTH-1:0] wData_q, wData_d;
  resp_e                 bresp_q, bresp_d;

  rd_state_e             rdState_q, rdState_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  awHs, wHs, arHs, commit, wrEn;
  logic                  wrInRange, arInRange;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [DATA_WIDTH-1:0] wrData, bankRdData;

  assign AWREADY = ARESETn && !awHeld_q && (wrState_q == W_IDLE);
  assign WREADY  = ARESETn && !wHeld_q && (wrState_q == W_IDLE);
  assign ARREADY = ARESETn && (rdState_q == R_IDLE);
  assign BVALID  = (wrState_q == W_RESP);
  assign BRESP   = bresp_q;
  assign RVALID  = (rdState_q == R_DATA);
  assign RDATA   = rdata_q;

  assign awHs = AWVALID && AWREADY;
  assign wHs  = WVALID && WREADY;
  assign arHs = ARVALID && ARREADY;

  // Held values take priority; otherwise the live bus carries this cycle's beat.
  assign wrAddr    = awHeld_q ? awAddr_q : AWADDR;
  assign wrData    = wHeld_q ? wData_q : WDATA;
  assign wrInRange = (wrAddr < ADDR_LIMIT);
  assign arInRange = (ARADDR < ADDR_LIMIT);
  assign commit    = (wrState_q == W_IDLE) && (awHeld_q || awHs) && (wHeld_q || wHs);
  assign wrEn      = commit && wrInRange;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wrState_q <= W_IDLE;
      awHeld_q  <= 1'b0;
      wHeld_q   <= 1'b0;
      awAddr_q  <= '0;
      wData_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rdState_q <= R_IDLE;
      rdata_q   <= '0;
    end else begin
      wrState_q <= wrState_d;
      awHeld_q  <= awHeld_d;
      wHeld_q   <= wHeld_d;
      awAddr_q  <= awAddr_d;
      wData_q   <= wData_d;
      bresp_q   <= bresp_d;
      rdState_q <= rdState_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    wrState_d = wrState_q;
    awHeld_d  = awHeld_q;
    wHeld_d   = wHeld_q;
    awAddr_d  = awAddr_q;
    wData_d   = wData_q;
    bresp_d   = bresp_q;
    unique case (wrState_q)
      W_IDLE: begin
        if (awHs) begin
          awHeld_d = 1'b1;
          awAddr_d = AWADDR;
        end
        if (wHs) begin
          wHeld_d = 1'b1;
          wData_d = WDATA;
        end
        if (commit) begin
          wrState_d = W_RESP;
          bresp_d   = wrInRange ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          wrState_d = W_IDLE;
          awHeld_d  = 1'b0;
          wHeld_d   = 1'b0;
        end
      end
      default: wrState_d = W_IDLE;
    endcase
  end

  always_comb begin
    rdState_d = rdState_q;
    rdata_d   = rdata_q;
    unique case (rdState_q)
      R_IDLE: begin
        if (arHs) begin
          rdState_d = R_DATA;
          rdata_d   = arInRange ? bankRdData : '0;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rdState_d = R_IDLE;
        end
      end
      default: rdState_d = R_IDLE;
    endcase
  end

  axi4_lite_reg_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_reg_bank (
    .clk_i    (ACLK),
    .rst_ni   (ARESETn),
    .wr_en_i  (wrEn),
    .wr_idx_i (wrAddr[IDX_W+1:2]),
    .wr_data_i(wrData),
    .rd_idx_i (ARADDR[IDX_W+1:2]),
    .rd_data_o(bankRdData),
    .regs_o   (regs_o)
  );

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
- AXI4-lite responder (slave) terminating all five channels of the team's AXI4-lite interface.
- Backs a bank of NUM_REGS word-wide read/write registers and exposes their contents to local hardware.
- Acts as the standard DUT/responder end for the master-side UVC and as a reusable CSR block.
- No WSTRB: every write is a full-word write.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR/ARADDR.
- DATA_WIDTH, 32, width of WDATA/RDATA and of each register.
- NUM_REGS, 16, number of registers (power of two, >=2).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset, asynchronous assert, active-low.
- AWADDR  in  ADDR_WIDTH  write address.
- AWVALID  in  1 / AWREADY  out  1  write address handshake.
- WDATA  in  DATA_WIDTH  write data.
- WVALID  in  1 / WREADY  out  1  write data handshake.
- BRESP  out  2  write response.
- BVALID  out  1 / BREADY  in  1  write response handshake.
- ARADDR  in  ADDR_WIDTH  read address.
- ARVALID  in  1 / ARREADY  out  1  read address handshake.
- RDATA  out  DATA_WIDTH  read data.
- RVALID  out  1 / RREADY  in  1  read data handshake.
- regs_o  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i sits at [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (ARESETn low): all registers 0, BVALID=0, BRESP=0, RVALID=0, RDATA=0. All READYs are forced 0 while ARESETn is low. Reset mid-transaction discards held address/data and any pending response.
- Address decode:
  - Byte address; bits [1:0] ignored.
  - index = addr[$clog2(NUM_REGS)+1:2].
  - Address is in range iff addr < NUM_REGS*4.
- Write path:
  - AW and W channels are accepted independently, in either order or in the same cycle.
  - Holding flags aw_held/w_held latch AWADDR/WDATA on their handshake.
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - Commit occurs on the edge where the second of the two handshakes completes, or both if simultaneous:
    - in range: reg[index] <= data, BRESP=OKAY (2'b00);
    - out of range: no register update, BRESP=SLVERR (2'b10).
  - BVALID rises on that same edge, so latency is 1 cycle after the last handshake. BVALID/BRESP stay stable until BREADY.
  - On the B handshake edge: BVALID<=0 and aw_held/w_held clear. READYs go high the following cycle.
  - Write FSM states: W_IDLE (collecting AW/W) -> W_RESP (BVALID) -> W_IDLE.
- Read path:
  - ARREADY = !RVALID.
  - On the AR handshake edge, RDATA <= reg[index] (in range) or 0 (out of range), and RVALID <= 1. Latency is 1 cycle.
  - RDATA/RVALID stay stable until RREADY; on the R handshake edge RVALID<=0.
  - Read FSM states: R_IDLE -> R_DATA -> R_IDLE.
- Collision: if a read-address handshake and a write commit to the same index fall on the same edge, the read returns the OLD value.
- Read and write paths operate fully concurrently.
- regs_o reflects a committed write starting the cycle after the commit edge.
- VALID outputs never drop without a handshake, except on reset.

Decomposition:
- Shared package axi4_lite_pkg:
  - resp enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - write/read FSM state typedefs;
  - default ADDR/DATA width localparams.
- One sub-module is natural: axi4_lite_reg_bank. It holds the register array, one write port (en/index/data), one combinational read port, and drives regs_o.
- The top module holds both channel FSMs and the address decode.

Test Plan:
1. AW(0x04) and W(0xA5A5_0001) in the same cycle, BREADY=1 -> BVALID next cycle, BRESP=00; read 0x04 returns 0xA5A5_0001 with RVALID 1 cycle after AR.
2. W(0x1234) 3 cycles before AW(0x08) -> WREADY low after W until B completes; BVALID 1 cycle after AW; reg2=0x1234.
3. Write 0x40 (NUM_REGS=16) -> BRESP=10, no register change; read 0x40 -> RDATA=0.
4. BREADY held 0 for 5 cycles -> BVALID/BRESP stable, AWREADY/WREADY stay 0; new AWVALID not accepted until after B handshake.
5. reg3=0x11 then same-edge AR(0x0C) and commit of 0x22 to 0x0C -> RDATA=0x11; subsequent read -> 0x22.
6. ARESETn pulsed low while aw_held and RVALID=1 -> all VALIDs 0, regs 0, READYs high after release; a fresh write completes normally.
